// File: rtl/pipememarb.sv
// Arbiter sharing one single-port memory between the fetch and MEM stages.
// Round-robin on ties, one access in flight, per-access ack timeout with err.
module pipememarb #(
  parameter int MAXWAIT = 15,
  parameter int DATA_W  = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              if_req,
  input  logic [DATA_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [DATA_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_ready,
  output logic              ram_en,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  input  logic              ram_ack,
  output logic              stall_if,
  output logic              stall_mem,
  output logic              err
);

  typedef enum logic [1:0] {IDLE, IF_WAIT, MEM_WAIT} state_t;

  // Last WAIT cycle index before the timeout fires.
  localparam logic [7:0] LAST_WAIT = 8'(MAXWAIT - 1);

  state_t            state, state_nxt;
  logic              last_mem, last_mem_nxt;
  logic [7:0]        wcnt, wcnt_nxt;
  logic [DATA_W-1:0] addr_q, addr_nxt;
  logic [DATA_W-1:0] wdata_q, wdata_nxt;
  logic              we_q, we_nxt;
  logic [DATA_W-1:0] if_rdata_nxt, mem_rdata_nxt;
  logic              if_ready_nxt, mem_ready_nxt, err_nxt;
  logic              grant_mem, grant_if;

  always_comb begin
    state_nxt     = state;
    last_mem_nxt  = last_mem;
    wcnt_nxt      = wcnt;
    addr_nxt      = addr_q;
    wdata_nxt     = wdata_q;
    we_nxt        = we_q;
    if_rdata_nxt  = if_rdata;
    mem_rdata_nxt = mem_rdata;
    if_ready_nxt  = 1'b0;
    mem_ready_nxt = 1'b0;
    err_nxt       = 1'b0;
    grant_mem     = 1'b0;
    grant_if      = 1'b0;
    case (state)
      IDLE: begin
        // A ready pulse means the finished requester still holds its request;
        // skipping this cycle keeps it from being granted a second time.
        if (!if_ready && !mem_ready) begin
          grant_mem = mem_req && (!if_req || !last_mem);
          grant_if  = if_req && !grant_mem;
        end
        if (grant_mem) begin
          state_nxt    = MEM_WAIT;
          addr_nxt     = mem_addr;
          wdata_nxt    = mem_wdata;
          we_nxt       = mem_we;
          last_mem_nxt = 1'b1;
          wcnt_nxt     = 8'd0;
        end else if (grant_if) begin
          state_nxt    = IF_WAIT;
          addr_nxt     = if_addr;
          wdata_nxt    = '0;
          we_nxt       = 1'b0;
          last_mem_nxt = 1'b0;
          wcnt_nxt     = 8'd0;
        end
      end
      IF_WAIT, MEM_WAIT: begin
        if (ram_ack) begin
          state_nxt = IDLE;
          if (state == IF_WAIT) begin
            if_ready_nxt = 1'b1;
            if_rdata_nxt = ram_rdata;
          end else begin
            mem_ready_nxt = 1'b1;
            if (!we_q) mem_rdata_nxt = ram_rdata;
          end
        end else if (wcnt >= LAST_WAIT) begin
          state_nxt = IDLE;
          err_nxt   = 1'b1;
          if (state == IF_WAIT) begin
            if_ready_nxt = 1'b1;
            if_rdata_nxt = '0;
          end else begin
            mem_ready_nxt = 1'b1;
            mem_rdata_nxt = '0;
          end
        end else begin
          wcnt_nxt = wcnt + 8'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      last_mem  <= 1'b0;
      wcnt      <= 8'd0;
      addr_q    <= '0;
      wdata_q   <= '0;
      we_q      <= 1'b0;
      if_rdata  <= '0;
      mem_rdata <= '0;
      if_ready  <= 1'b0;
      mem_ready <= 1'b0;
      err       <= 1'b0;
    end else begin
      state     <= state_nxt;
      last_mem  <= last_mem_nxt;
      wcnt      <= wcnt_nxt;
      addr_q    <= addr_nxt;
      wdata_q   <= wdata_nxt;
      we_q      <= we_nxt;
      if_rdata  <= if_rdata_nxt;
      mem_rdata <= mem_rdata_nxt;
      if_ready  <= if_ready_nxt;
      mem_ready <= mem_ready_nxt;
      err       <= err_nxt;
    end
  end

  assign ram_en    = (state != IDLE);
  assign ram_we    = (state == MEM_WAIT) && we_q;
  assign ram_addr  = addr_q;
  assign ram_wdata = wdata_q;
  assign stall_if  = if_req & ~if_ready;
  assign stall_mem = mem_req & ~mem_ready;

endmodule

// File: tb/tb_pipememarb.sv
// Bench for pipememarb: directed scenarios plus a randomized run checked
// against a transaction-level arbiter/memory model.
module tb_pipememarb;
  localparam int MAXWAIT = 15;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic [31:0] if_rdata;
  logic        if_ready;
  logic        mem_req = 1'b0;
  logic        mem_we = 1'b0;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_wdata = '0;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        ram_en, ram_we;
  logic [31:0] ram_addr, ram_wdata;
  logic [31:0] ram_rdata = '0;
  logic        ram_ack = 1'b0;
  logic        stall_if, stall_mem, err;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  pipememarb #(.MAXWAIT(MAXWAIT)) dut (
    .clock(clock), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .ram_ack(ram_ack),
    .stall_if(stall_if), .stall_mem(stall_mem), .err(err)
  );

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic apply_reset();
    reset = 1'b1; if_req = 1'b0; mem_req = 1'b0; ram_ack = 1'b0;
    tick(); tick();
    reset = 1'b0;
  endtask

  // Waits (bounded) for ram_en; n is the number of cycles it took.
  task automatic wait_en(input int limit, output int n, output bit ok);
    n = 0; ok = 1'b0;
    while (n < limit && !ok) begin
      if (ram_en === 1'b1) ok = 1'b1;
      else begin tick(); n++; end
    end
  endtask

  task automatic test_reset();
    apply_reset();
    total++; if (ram_en !== 1'b0 || ram_we !== 1'b0) begin bad++;
      $display("FAIL reset_ram en=%b we=%b want 0 0", ram_en, ram_we); end
    total++; if (if_ready !== 1'b0 || mem_ready !== 1'b0 || err !== 1'b0) begin bad++;
      $display("FAIL reset_pulses if_ready=%b mem_ready=%b err=%b want 000", if_ready, mem_ready, err); end
    total++; if (if_rdata !== 32'h0 || mem_rdata !== 32'h0) begin bad++;
      $display("FAIL reset_rdata if=%h mem=%h want 0", if_rdata, mem_rdata); end
    total++; if (stall_if !== 1'b0 || stall_mem !== 1'b0) begin bad++;
      $display("FAIL reset_stall if=%b mem=%b want 0 0", stall_if, stall_mem); end
  endtask

  task automatic test_fetch();
    int n; bit ok;
    apply_reset();
    if_addr = 32'h40; if_req = 1'b1; #1;
    total++; if (stall_if !== 1'b1) begin bad++;
      $display("FAIL fetch_stall_early got=%b want 1", stall_if); end
    wait_en(4, n, ok);
    total++; if (!ok || n != 1) begin bad++;
      $display("FAIL fetch_grant_latency ok=%0d cycles=%0d want 1", ok, n); end
    total++; if (ram_addr !== 32'h40 || ram_we !== 1'b0) begin bad++;
      $display("FAIL fetch_ram addr=%h we=%b want 00000040 0", ram_addr, ram_we); end
    tick(); tick();
    ram_ack = 1'b1; ram_rdata = 32'h8C220004;
    total++; if (if_ready !== 1'b0 || stall_if !== 1'b1 || ram_en !== 1'b1) begin bad++;
      $display("FAIL fetch_wait ready=%b stall=%b en=%b want 0 1 1", if_ready, stall_if, ram_en); end
    tick();
    ram_ack = 1'b0; ram_rdata = $urandom;
    total++; if (if_ready !== 1'b1 || if_rdata !== 32'h8C220004) begin bad++;
      $display("FAIL fetch_done ready=%b rdata=%h want 1 8c220004", if_ready, if_rdata); end
    total++; if (stall_if !== 1'b0 || err !== 1'b0 || mem_ready !== 1'b0 || ram_en !== 1'b0) begin bad++;
      $display("FAIL fetch_done_side stall=%b err=%b mem_ready=%b en=%b want 0000", stall_if, err, mem_ready, ram_en); end
    if_req = 1'b0;
    tick();
    total++; if (if_ready !== 1'b0) begin bad++;
      $display("FAIL fetch_pulse_width ready=%b want 0", if_ready); end
  endtask

  task automatic test_tie_store();
    int n; bit ok;
    apply_reset();
    mem_we = 1'b1; mem_addr = 32'h100; mem_wdata = 32'hDEADBEEF; if_addr = 32'h44;
    mem_req = 1'b1; if_req = 1'b1;
    wait_en(4, n, ok);
    total++; if (!ok || ram_we !== 1'b1 || ram_addr !== 32'h100 || ram_wdata !== 32'hDEADBEEF) begin bad++;
      $display("FAIL tie_store_first we=%b addr=%h wdata=%h want 1 00000100 deadbeef", ram_we, ram_addr, ram_wdata); end
    ram_ack = 1'b1; ram_rdata = 32'h13572468;
    tick();
    ram_ack = 1'b0;
    total++; if (mem_ready !== 1'b1 || if_ready !== 1'b0 || err !== 1'b0 || mem_rdata !== 32'h0) begin bad++;
      $display("FAIL tie_store_done mem_ready=%b if_ready=%b err=%b mem_rdata=%h want 1 0 0 0", mem_ready, if_ready, err, mem_rdata); end
    mem_req = 1'b0; mem_we = 1'b0;
    wait_en(4, n, ok);
    total++; if (!ok || n != 2 || ram_we !== 1'b0 || ram_addr !== 32'h44) begin bad++;
      $display("FAIL tie_fetch_second ok=%0d gap=%0d we=%b addr=%h want 1 2 0 00000044", ok, n, ram_we, ram_addr); end
    ram_ack = 1'b1; ram_rdata = 32'hA5A5_0001;
    tick();
    ram_ack = 1'b0;
    total++; if (if_ready !== 1'b1 || if_rdata !== 32'hA5A5_0001) begin bad++;
      $display("FAIL tie_fetch_done ready=%b rdata=%h want 1 a5a50001", if_ready, if_rdata); end
    if_req = 1'b0;
    tick();
  endtask

  task automatic test_alternate();
    int order[$];
    bit pi, pm;
    apply_reset();
    if_addr = 32'h80; mem_addr = 32'h180; mem_we = 1'b0;
    if_req = 1'b1; mem_req = 1'b1; pi = 1'b0; pm = 1'b0;
    for (int c = 0; c < 30; c++) begin
      if (mem_ready === 1'b1) order.push_back(1);
      if (if_ready === 1'b1) order.push_back(2);
      total++; if ((pi && if_ready) || (pm && mem_ready) || (if_ready && mem_ready)) begin bad++;
        $display("FAIL alt_pulse cycle=%0d if_ready=%b mem_ready=%b prev=%b%b", c, if_ready, mem_ready, pi, pm); end
      pi = if_ready; pm = mem_ready;
      ram_ack = ram_en; ram_rdata = $urandom;
      tick();
    end
    ram_ack = 1'b0; if_req = 1'b0; mem_req = 1'b0;
    total++; if (order.size() < 4) begin bad++;
      $display("FAIL alt_count got=%0d want >=4", order.size()); end
    else begin
      for (int i = 0; i < 4; i++) begin
        total++; if (order[i] != ((i % 2 == 0) ? 1 : 2)) begin bad++;
          $display("FAIL alt_order idx=%0d got=%0d want=%0d (1=MEM 2=IF)", i, order[i], (i % 2 == 0) ? 1 : 2); end
      end
    end
    tick(); tick();
  endtask

  task automatic test_timeout();
    int n, cnt; bit ok;
    apply_reset();
    mem_addr = 32'h200; mem_we = 1'b0; mem_req = 1'b1;
    wait_en(4, n, ok);
    ram_ack = 1'b1; ram_rdata = 32'h12345678;
    tick();
    ram_ack = 1'b0;
    total++; if (mem_ready !== 1'b1 || mem_rdata !== 32'h12345678) begin bad++;
      $display("FAIL to_preload ready=%b rdata=%h want 1 12345678", mem_ready, mem_rdata); end
    mem_req = 1'b0;
    tick();
    mem_addr = 32'h204; mem_req = 1'b1;
    wait_en(4, n, ok);
    cnt = 0;
    while (ram_en === 1'b1 && cnt < 40) begin
      ram_rdata = $urandom;
      cnt++; tick();
    end
    total++; if (cnt != MAXWAIT) begin bad++;
      $display("FAIL to_wait_cycles got=%0d want=%0d", cnt, MAXWAIT); end
    total++; if (mem_ready !== 1'b1 || err !== 1'b1 || mem_rdata !== 32'h0 || ram_en !== 1'b0) begin bad++;
      $display("FAIL to_done ready=%b err=%b rdata=%h en=%b want 1 1 0 0", mem_ready, err, mem_rdata, ram_en); end
    mem_req = 1'b0;
    tick();
    total++; if (mem_ready !== 1'b0 || err !== 1'b0) begin bad++;
      $display("FAIL to_pulse_width ready=%b err=%b want 0 0", mem_ready, err); end
    if_addr = 32'h48; if_req = 1'b1;
    wait_en(4, n, ok);
    total++; if (!ok || n != 1 || ram_addr !== 32'h48) begin bad++;
      $display("FAIL to_back_to_idle ok=%0d cycles=%0d addr=%h want 1 1 00000048", ok, n, ram_addr); end
    ram_ack = 1'b1; tick(); ram_ack = 1'b0; if_req = 1'b0; tick();
  endtask

  task automatic test_ack_at_limit();
    int n; bit ok;
    apply_reset();
    mem_addr = 32'h300; mem_we = 1'b0; mem_req = 1'b1;
    wait_en(4, n, ok);
    for (int w = 0; w < MAXWAIT - 1; w++) begin
      ram_rdata = $urandom; tick();
    end
    total++; if (ram_en !== 1'b1 || mem_ready !== 1'b0) begin bad++;
      $display("FAIL limit_still_waiting en=%b ready=%b want 1 0", ram_en, mem_ready); end
    ram_ack = 1'b1; ram_rdata = 32'hCAFEF00D;
    tick();
    ram_ack = 1'b0;
    total++; if (mem_ready !== 1'b1 || err !== 1'b0 || mem_rdata !== 32'hCAFEF00D) begin bad++;
      $display("FAIL limit_ack_wins ready=%b err=%b rdata=%h want 1 0 cafef00d", mem_ready, err, mem_rdata); end
    mem_req = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    int n; bit ok;
    apply_reset();
    mem_addr = 32'h240; mem_we = 1'b0; mem_req = 1'b1;
    wait_en(4, n, ok);
    reset = 1'b1; mem_req = 1'b0;
    tick();
    reset = 1'b0; ram_ack = 1'b1; ram_rdata = 32'h55AA55AA;
    total++; if (ram_en !== 1'b0 || mem_ready !== 1'b0) begin bad++;
      $display("FAIL rstmid_abandon en=%b ready=%b want 0 0", ram_en, mem_ready); end
    tick();
    ram_ack = 1'b0;
    for (int c = 0; c < 3; c++) begin
      total++; if (mem_ready !== 1'b0 || err !== 1'b0 || ram_en !== 1'b0 || mem_rdata !== 32'h0) begin bad++;
        $display("FAIL rstmid_late_ack cycle=%0d ready=%b err=%b en=%b rdata=%h want 0 0 0 0", c, mem_ready, err, ram_en, mem_rdata); end
      tick();
    end
    // last_grant is back to IF after reset, so the store/load side wins this tie
    if_addr = 32'h88; mem_addr = 32'h248; if_req = 1'b1; mem_req = 1'b1;
    wait_en(4, n, ok);
    total++; if (!ok || ram_addr !== 32'h248) begin bad++;
      $display("FAIL rstmid_tie addr=%h want 00000248", ram_addr); end
    ram_ack = 1'b1; tick(); ram_ack = 1'b0; mem_req = 1'b0;
    wait_en(4, n, ok);
    ram_ack = 1'b1; tick(); ram_ack = 1'b0; if_req = 1'b0; tick();
  endtask

  task automatic test_random();
    logic [31:0] img [16];
    logic [31:0] exp_if, exp_mem, exp_data, exp_addr;
    bit last_mem, win_mem, to, ok;
    int delay, n, waits;
    apply_reset();
    for (int i = 0; i < 16; i++) img[i] = $urandom;
    last_mem = 1'b0; exp_if = '0; exp_mem = '0;
    for (int t = 0; t < 60; t++) begin
      if (!if_req && $urandom_range(1, 0) == 1) begin
        if_addr = 32'h1000 | (32'($urandom_range(15, 0)) << 2); if_req = 1'b1;
      end
      if (!mem_req && $urandom_range(1, 0) == 1) begin
        mem_addr = 32'h1000 | (32'($urandom_range(15, 0)) << 2);
        mem_we = 1'($urandom_range(1, 0)); mem_wdata = $urandom; mem_req = 1'b1;
      end
      if (!if_req && !mem_req) begin
        if_addr = 32'h1000 | (32'($urandom_range(15, 0)) << 2); if_req = 1'b1;
      end
      win_mem  = mem_req && (!if_req || !last_mem);
      exp_addr = win_mem ? mem_addr : if_addr;
      delay    = $urandom_range(17, 0);
      to       = (delay >= MAXWAIT);
      wait_en(4, n, ok);
      total++; if (!ok || n != 1) begin bad++;
        $display("FAIL rnd_grant t=%0d ok=%0d cycles=%0d want 1", t, ok, n); end
      total++; if (ram_addr !== exp_addr || ram_we !== (win_mem && mem_we) ||
                   (win_mem && mem_we && ram_wdata !== mem_wdata)) begin bad++;
        $display("FAIL rnd_ram t=%0d addr=%h we=%b wdata=%h want addr=%h we=%b", t, ram_addr, ram_we, ram_wdata, exp_addr, win_mem && mem_we); end
      total++; if (stall_if !== if_req || stall_mem !== mem_req) begin bad++;
        $display("FAIL rnd_stall t=%0d if=%b mem=%b want %b %b", t, stall_if, stall_mem, if_req, mem_req); end
      waits = to ? MAXWAIT : delay;
      for (int w = 0; w < waits; w++) begin
        total++; if (ram_en !== 1'b1 || if_ready !== 1'b0 || mem_ready !== 1'b0) begin bad++;
          $display("FAIL rnd_wait t=%0d w=%0d en=%b rdy=%b%b want 1 00", t, w, ram_en, if_ready, mem_ready); end
        ram_rdata = $urandom;
        tick();
      end
      exp_data = img[exp_addr[5:2]];
      if (!to) begin
        ram_ack = 1'b1;
        ram_rdata = (win_mem && mem_we) ? $urandom : exp_data;
        tick();
        ram_ack = 1'b0;
      end
      if (win_mem) begin
        if (to) exp_mem = '0;
        else if (!mem_we) exp_mem = exp_data;
        else img[exp_addr[5:2]] = mem_wdata;
      end else begin
        exp_if = to ? 32'h0 : exp_data;
      end
      total++; if (mem_ready !== win_mem || if_ready !== !win_mem || err !== to || ram_en !== 1'b0) begin bad++;
        $display("FAIL rnd_done t=%0d mem_rdy=%b if_rdy=%b err=%b en=%b want %b %b %b 0", t, mem_ready, if_ready, err, ram_en, win_mem, !win_mem, to); end
      total++; if (if_rdata !== exp_if || mem_rdata !== exp_mem) begin bad++;
        $display("FAIL rnd_rdata t=%0d if=%h mem=%h want %h %h", t, if_rdata, mem_rdata, exp_if, exp_mem); end
      total++; if ((win_mem ? stall_mem : stall_if) !== 1'b0) begin bad++;
        $display("FAIL rnd_stall_done t=%0d got 1 want 0", t); end
      last_mem = win_mem;
      if (win_mem) mem_req = 1'b0; else if_req = 1'b0;
      tick();
      total++; if (if_ready !== 1'b0 || mem_ready !== 1'b0 || err !== 1'b0) begin bad++;
        $display("FAIL rnd_pulse_width t=%0d rdy=%b%b err=%b want 000", t, if_ready, mem_ready, err); end
    end
    if_req = 1'b0; mem_req = 1'b0;
    tick(); tick();
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_tie_store();
    test_alternate();
    test_timeout();
    test_ack_at_limit();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
